// File: rtl/adder_chk_pkg.sv
// Shared definitions for adder response checkers: FSM encoding, counter width
// and the full-coverage pattern of the LSB-slice input map.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          CNT_W    = 16;
  localparam logic [7:0]  COV_FULL = 8'hFF;

endpackage

// File: rtl/adder_golden.sv
// Golden reference adder: {cout,sum} = a + b + cin evaluated at WIDTH+1 bits.
module adder_golden #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_response_checker.sv
// Compares observed adder results against a golden a+b+cin in a two-stage
// pipeline, accumulating sample/error counts, LSB coverage and the first failure.
module adder_response_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int NUM_SAMPLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    input  logic [WIDTH-1:0]   obs_sum,
    input  logic               obs_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [7:0]         cov_map,
    output logic [2*WIDTH:0]   first_err_vec,
    output logic               first_err_valid
);

    localparam int              VEC_W    = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    state_t state, state_nxt;

    logic             in_run, is_last, accept, clear;
    logic [WIDTH-1:0] gold_sum;
    logic             gold_cout;

    logic             s1_valid;
    logic [VEC_W-1:0] s1_vec;
    logic [WIDTH:0]   s1_exp, s1_obs;
    logic             s1_mismatch;
    logic [2:0]       cov_idx;

    assign in_run  = (state == ST_RUN);
    assign is_last = (sample_count == LAST_IDX);
    // A stop pulse drops its own sample unless that sample completes the run.
    assign accept  = in_run && in_valid && (!stop || is_last);
    assign clear   = start && !in_run;

    adder_golden #(.WIDTH(WIDTH)) u_golden (
        .a    (in_a),
        .b    (in_b),
        .cin  (in_cin),
        .sum  (gold_sum),
        .cout (gold_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first, so no path through the case leaves
    // state_nxt unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if ((accept && is_last) || stop) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = start ? ST_RUN : ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DRAIN);
        done = (state == ST_DONE);
        pass = done && (err_count == '0) && (cov_map == COV_FULL);
    end

    // Stage 1: capture the vector with its expected and observed results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_vec       <= '0;
            s1_exp       <= '0;
            s1_obs       <= '0;
            sample_count <= '0;
        end else if (clear) begin
            s1_valid     <= 1'b0;
            sample_count <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_vec       <= {in_a, in_b, in_cin};
                s1_exp       <= {gold_cout, gold_sum};
                s1_obs       <= {obs_cout, obs_sum};
                sample_count <= sample_count + 1'b1;
            end
        end
    end

    assign s1_mismatch = (s1_exp != s1_obs);
    assign cov_idx     = {s1_vec[WIDTH+1], s1_vec[1], s1_vec[0]};

    // Stage 2: fold the registered sample into the run results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count       <= '0;
            cov_map         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (clear) begin
            err_count       <= '0;
            cov_map         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (s1_valid) begin
            cov_map <= cov_map | (8'b1 << cov_idx);
            if (s1_mismatch) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_vec   <= s1_vec;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end

endmodule
